// File: rtl/writeback_reg_file_pkg.sv
// Shared definitions for the writeback register file slice.
// Holds the functional-unit codes, GPR geometry, the bit positions of the
// CR field nibble and the XER OV/CA bits inside reg2WritebackVal_i.
// The bit positions use big-endian numbering: bit 0 is the MSB of the vector.
package writeback_reg_file_pkg;

    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 64;

    localparam logic [1:0] FX_UNIT_CODE   = 2'd0;
    localparam logic [1:0] LDST_UNIT_CODE = 2'd2;

    // Offsets of the four flags within one 4-bit CR field, and their
    // positions inside reg2WritebackVal_i for an FX writeback.
    localparam int CR_LT = 0;
    localparam int CR_GT = 1;
    localparam int CR_EQ = 2;
    localparam int CR_SO = 3;

    localparam int XER_OV_POS = 4;
    localparam int XER_CA_POS = 5;

    // First CR bit (big-endian) of CR field f.
    function automatic logic [4:0] cr_field_base(input logic [2:0] f);
        return {f, 2'b00};
    endfunction

endpackage

// File: rtl/writeback_reg_file_scoreboard.sv
// regfile_scoreboard: one busy flag per GPR.
//   clock_i, reset_i        clock, asynchronous active-low reset
//   set_en_i/set_addr_i     dispatch reserves a destination GPR
//   clr1_*/clr2_*           committed GPR writes that retire a producer
//   rd_addr_i[3]            three read indices
//   busy_o[3]               busy flag for each read index
// Set beats clear on the same index because the reserve is a newer producer.
// Optional macro WB_BYPASS_EN: a same-cycle clear (without a same-cycle set)
// is reflected on busy_o immediately.
module regfile_scoreboard
    import writeback_reg_file_pkg::*;
#(
    parameter int regWidth = REG_WIDTH
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     set_en_i,
    input  logic [regWidth-1:0]      set_addr_i,
    input  logic                     clr1_en_i,
    input  logic [regWidth-1:0]      clr1_addr_i,
    input  logic                     clr2_en_i,
    input  logic [regWidth-1:0]      clr2_addr_i,
    input  logic [2:0][regWidth-1:0] rd_addr_i,
    output logic [2:0]               busy_o
);

    localparam int numRegs = 2 ** regWidth;

    logic [numRegs-1:0] busy_q;
    logic [numRegs-1:0] busy_d;
    logic [numRegs-1:0] set_hit;
    logic [numRegs-1:0] clr_hit;

    genvar gi;
    generate
        for (gi = 0; gi < numRegs; gi++) begin : g_busy
            assign set_hit[gi] = set_en_i && (set_addr_i == regWidth'(gi));
            assign clr_hit[gi] = (clr1_en_i && (clr1_addr_i == regWidth'(gi)))
                              || (clr2_en_i && (clr2_addr_i == regWidth'(gi)));
            assign busy_d[gi]  = set_hit[gi] | (busy_q[gi] & ~clr_hit[gi]);

            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    busy_q[gi] <= 1'b0;
                end else begin
                    busy_q[gi] <= busy_d[gi];
                end
            end
        end

        for (gi = 0; gi < 3; gi++) begin : g_read
`ifdef WB_BYPASS_EN
            // A retiring producer reads as not-busy this cycle unless a new
            // reserve lands on the same register.
            assign busy_o[gi] = busy_q[rd_addr_i[gi]]
                              & ~(clr_hit[rd_addr_i[gi]] & ~set_hit[rd_addr_i[gi]]);
`else
            assign busy_o[gi] = busy_q[rd_addr_i[gi]];
`endif
        end
    endgenerate

endmodule

// File: rtl/writeback_reg_file.sv
// writeback_reg_file: commits the writeback mux bundle into architected state.
//   clock_i, reset_i            clock, asynchronous active-low reset
//   functionalUnitCode_i        producing unit (FX or LS decide reg2 meaning)
//   reg1Writeback*_i            port-1 GPR write (any unit)
//   reg2Writeback*_i            FX: CR field + XER OV/CA; LS: second GPR write
//   readAddr{A,B,C}_i           combinational GPR read indices
//   readData{A,B,C}_o           GPR read data
//   readBusy{A,B,C}_o           scoreboard flag of the addressed GPR
//   reserveEnable_i/Addr_i      dispatch marks a GPR in flight
//   cr_o, xerOV_o, xerCA_o      condition register and XER bits
// Vectors use big-endian bit numbering ([0:N-1]), matching the architecture.
// Optional macro WB_BYPASS_EN: reads forward the same-cycle writeback value
// (port1 over port2) and see the same-cycle busy clear.
module writeback_reg_file
    import writeback_reg_file_pkg::*;
#(
    parameter int         regWidth     = REG_WIDTH,
    parameter int         dataWidth    = DATA_WIDTH,
    parameter logic [1:0] FXUnitCode   = FX_UNIT_CODE,
    parameter logic [1:0] LdStUnitCode = LDST_UNIT_CODE
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [1:0]            functionalUnitCode_i,
    input  logic                  reg1WritebackEnable_i,
    input  logic                  reg2WritebackEnable_i,
    input  logic [0:regWidth]     reg1WritebackAddress_i,
    input  logic [0:regWidth]     reg2WritebackAddress_i,
    input  logic [0:dataWidth-1]  reg1WritebackVal_i,
    input  logic [0:dataWidth-1]  reg2WritebackVal_i,
    input  logic [regWidth-1:0]   readAddrA_i,
    input  logic [regWidth-1:0]   readAddrB_i,
    input  logic [regWidth-1:0]   readAddrC_i,
    output logic [0:dataWidth-1]  readDataA_o,
    output logic [0:dataWidth-1]  readDataB_o,
    output logic [0:dataWidth-1]  readDataC_o,
    output logic                  readBusyA_o,
    output logic                  readBusyB_o,
    output logic                  readBusyC_o,
    input  logic                  reserveEnable_i,
    input  logic [regWidth-1:0]   reserveAddr_i,
    output logic [0:31]           cr_o,
    output logic                  xerOV_o,
    output logic                  xerCA_o
);

    localparam int numRegs = 2 ** regWidth;

    logic [0:dataWidth-1] gpr_q [numRegs];
    logic [0:31]          cr_q, cr_d;
    logic                 xer_ov_q, xer_ov_d;
    logic                 xer_ca_q, xer_ca_d;

    // Decoded write candidates. Address bit 0 is never part of a GPR index.
    logic                wr1_en, wr2_en, cr_upd;
    logic [regWidth-1:0] wr1_addr, wr2_addr;
    logic [2:0]          cr_field;

    assign wr1_en   = reg1WritebackEnable_i;
    assign wr1_addr = reg1WritebackAddress_i[1:regWidth];
    assign wr2_en   = reg2WritebackEnable_i && (functionalUnitCode_i == LdStUnitCode);
    assign wr2_addr = reg2WritebackAddress_i[1:regWidth];
    assign cr_upd   = reg2WritebackEnable_i && (functionalUnitCode_i == FXUnitCode);
    assign cr_field = reg2WritebackAddress_i[regWidth-2:regWidth];

    logic unused_addr_bits;
    assign unused_addr_bits = reg1WritebackAddress_i[0] ^ reg2WritebackAddress_i[0];

    // GPR array: port2 is written first so port1 overrides on an address clash.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < numRegs; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            if (wr2_en) begin
                gpr_q[wr2_addr] <= reg2WritebackVal_i;
            end
            if (wr1_en) begin
                gpr_q[wr1_addr] <= reg1WritebackVal_i;
            end
        end
    end

    always_comb begin
        cr_d     = cr_q;
        xer_ov_d = xer_ov_q;
        xer_ca_d = xer_ca_q;
        if (cr_upd) begin
            cr_d[cr_field_base(cr_field) +: 4] = reg2WritebackVal_i[CR_LT:CR_SO];
            // A summary-overflow result also flags overflow in XER.
            xer_ov_d = reg2WritebackVal_i[XER_OV_POS] | reg2WritebackVal_i[CR_SO];
            xer_ca_d = reg2WritebackVal_i[XER_CA_POS];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cr_q     <= '0;
            xer_ov_q <= 1'b0;
            xer_ca_q <= 1'b0;
        end else begin
            cr_q     <= cr_d;
            xer_ov_q <= xer_ov_d;
            xer_ca_q <= xer_ca_d;
        end
    end

    assign cr_o    = cr_q;
    assign xerOV_o = xer_ov_q;
    assign xerCA_o = xer_ca_q;

    // Three read ports.
    logic [2:0][regWidth-1:0] rd_addr;
    logic [0:dataWidth-1]     rd_data [3];
    logic [2:0]               rd_busy;

    assign rd_addr = {readAddrC_i, readAddrB_i, readAddrA_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = gpr_q[rd_addr[gi]];
`ifdef WB_BYPASS_EN
                if (wr1_en && (wr1_addr == rd_addr[gi])) begin
                    rd_data[gi] = reg1WritebackVal_i;
                end else if (wr2_en && (wr2_addr == rd_addr[gi])) begin
                    rd_data[gi] = reg2WritebackVal_i;
                end
`endif
            end
        end
    endgenerate

    assign readDataA_o = rd_data[0];
    assign readDataB_o = rd_data[1];
    assign readDataC_o = rd_data[2];
    assign readBusyA_o = rd_busy[0];
    assign readBusyB_o = rd_busy[1];
    assign readBusyC_o = rd_busy[2];

    regfile_scoreboard #(
        .regWidth (regWidth)
    ) u_scoreboard (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .set_en_i    (reserveEnable_i),
        .set_addr_i  (reserveAddr_i),
        .clr1_en_i   (wr1_en),
        .clr1_addr_i (wr1_addr),
        .clr2_en_i   (wr2_en),
        .clr2_addr_i (wr2_addr),
        .rd_addr_i   (rd_addr),
        .busy_o      (rd_busy)
    );

endmodule

// File: tb/tb_writeback_reg_file.sv
// Self-checking bench for writeback_reg_file: directed steps from the test
// plan followed by random traffic against an architectural model kept as
// plain arrays. Vectors here are numeric [N-1:0]; big-endian bit k of the
// DUT maps to numeric bit N-1-k.
module tb_writeback_reg_file;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  unit;
    logic        en1, en2;
    logic [5:0]  a1, a2;
    logic [63:0] v1, v2;
    logic [4:0]  ra_a, ra_b, ra_c;
    logic [63:0] rd_a, rd_b, rd_c;
    logic        bz_a, bz_b, bz_c;
    logic        resv;
    logic [4:0]  resv_a;
    logic [31:0] cr;
    logic        ov, ca;

    always #5 clock = ~clock;

    writeback_reg_file dut (
        .clock_i                (clock),
        .reset_i                (reset_n),
        .functionalUnitCode_i   (unit),
        .reg1WritebackEnable_i  (en1),
        .reg2WritebackEnable_i  (en2),
        .reg1WritebackAddress_i (a1),
        .reg2WritebackAddress_i (a2),
        .reg1WritebackVal_i     (v1),
        .reg2WritebackVal_i     (v2),
        .readAddrA_i            (ra_a),
        .readAddrB_i            (ra_b),
        .readAddrC_i            (ra_c),
        .readDataA_o            (rd_a),
        .readDataB_o            (rd_b),
        .readDataC_o            (rd_c),
        .readBusyA_o            (bz_a),
        .readBusyB_o            (bz_b),
        .readBusyC_o            (bz_c),
        .reserveEnable_i        (resv),
        .reserveAddr_i          (resv_a),
        .cr_o                   (cr),
        .xerOV_o                (ov),
        .xerCA_o                (ca)
    );

    // Architectural model.
    logic [63:0] m_gpr [32];
    bit          m_busy [32];
    logic [31:0] m_cr;
    logic        m_ov, m_ca;

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_gpr[i]  = '0;
            m_busy[i] = 0;
        end
        m_cr = '0;
        m_ov = 0;
        m_ca = 0;
    endtask

    task automatic idle();
        en1 = 0; en2 = 0; resv = 0; unit = 2'd0;
        a1 = '0; a2 = '0; v1 = '0; v2 = '0; resv_a = '0;
    endtask

    function automatic bit ls_write();
        return en2 && (unit == 2'd2);
    endfunction

    // What a read port should show right now (before the coming edge).
    function automatic logic [63:0] exp_data(input logic [4:0] ra);
`ifdef WB_BYPASS_EN
        if (en1 && a1[4:0] == ra) return v1;
        if (ls_write() && a2[4:0] == ra) return v2;
`endif
        return m_gpr[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
`ifdef WB_BYPASS_EN
        bit retiring = (en1 && a1[4:0] == ra) || (ls_write() && a2[4:0] == ra);
        if (retiring && !(resv && resv_a == ra)) return 1'b0;
`endif
        return m_busy[ra] ? 1'b1 : 1'b0;
    endfunction

    task automatic check_reads(input string tag);
        chk({tag, "_dataA"}, rd_a, exp_data(ra_a));
        chk({tag, "_dataB"}, rd_b, exp_data(ra_b));
        chk({tag, "_dataC"}, rd_c, exp_data(ra_c));
        chk({tag, "_busyA"}, 64'(bz_a), 64'(exp_busy(ra_a)));
        chk({tag, "_busyB"}, 64'(bz_b), 64'(exp_busy(ra_b)));
        chk({tag, "_busyC"}, 64'(bz_c), 64'(exp_busy(ra_c)));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cr"}, 64'(cr), 64'(m_cr));
        chk({tag, "_ov"}, 64'(ov), 64'(m_ov));
        chk({tag, "_ca"}, 64'(ca), 64'(m_ca));
    endtask

    // One clock edge; the model then applies the writeback rules to the
    // inputs that were held across that edge.
    task automatic tick();
        int sh;
        @(posedge clock);
        #1;
        n_txn++;
        $display("txn %0d rst_n=%0d unit=%0d en1=%0d a1=%0d v1=%h en2=%0d a2=%0d v2=%h resv=%0d@%0d",
                 n_txn, reset_n, unit, en1, a1[4:0], v1, en2, a2, v2, resv, resv_a);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (ls_write()) begin
                m_gpr[a2[4:0]]  = v2;
                m_busy[a2[4:0]] = 0;
            end
            if (en1) begin
                m_gpr[a1[4:0]]  = v1;
                m_busy[a1[4:0]] = 0;
            end
            if (resv) m_busy[resv_a] = 1;
            if (en2 && unit == 2'd0) begin
                sh   = 28 - 4 * int'(a2[2:0]);
                m_cr = (m_cr & ~(32'hF << sh)) | (32'(v2[63:60]) << sh);
                m_ov = v2[59] | v2[60];
                m_ca = v2[58];
            end
        end
    endtask

    initial begin
        reset_n = 0;
        idle();
        ra_a = 0; ra_b = 5; ra_c = 31;
        model_reset();

        // Writes and reserves presented during reset are dropped.
        en1 = 1; a1 = 6'd5; v1 = 64'h1234; resv = 1; resv_a = 5'd5;
        tick();
        tick();
        #2 reset_n = 1;
        idle();
        #1;
        check_reads("reset");
        check_state("reset");
        chk("reset_cr_zero", 64'(cr), 64'd0);

        // FX write with CR field 2 = 1011, OV=0 but SO forces OV, CA=1.
        unit = 2'd0; en1 = 1; a1 = 6'd7; v1 = 64'hDEADBEEF00000001;
        en2 = 1; a2 = 6'd2; v2 = {6'b101101, 58'd0};
        tick();
        idle();
        ra_a = 7; #1;
        check_reads("fx");
        check_state("fx");
        chk("fx_gpr7", rd_a, 64'hDEADBEEF00000001);
        chk("fx_cr_const", 64'(cr), 64'h0000_0000_00B0_0000);
        chk("fx_ov_const", 64'(ov), 64'd1);

        // LS dual write, then both ports on GPR 9 (port1 wins).
        unit = 2'd2; en1 = 1; a1 = 6'd3; v1 = 64'h11; en2 = 1; a2 = 6'd4; v2 = 64'h22;
        tick();
        unit = 2'd2; en1 = 1; a1 = 6'd9; v1 = 64'h33; en2 = 1; a2 = 6'd9; v2 = 64'h44;
        tick();
        idle();
        ra_a = 3; ra_b = 4; ra_c = 9; #1;
        check_reads("ls");
        chk("ls_gpr9_port1", rd_c, 64'h33);
        check_state("ls");

        // Scoreboard: reserve, reserve+retire together, lone retire.
        ra_a = 12; ra_b = 4; ra_c = 9;
        resv = 1; resv_a = 5'd12;
        tick();
        idle(); #1;
        chk("sb_reserved", 64'(bz_a), 64'd1);
        en1 = 1; a1 = 6'd12; v1 = 64'h5; resv = 1; resv_a = 5'd12;
        tick();
        idle(); #1;
        chk("sb_set_wins", 64'(bz_a), 64'd1);
        en1 = 1; a1 = 6'd12; v1 = 64'h6;
        tick();
        idle(); #1;
        chk("sb_cleared", 64'(bz_a), 64'd0);
        check_reads("sb");

        // Same-cycle read of a writeback target.
        ra_a = 20;
        en1 = 1; a1 = 6'd20; v1 = 64'hABCD;
        #1;
`ifdef WB_BYPASS_EN
        chk("bypass_same_cycle", rd_a, 64'hABCD);
`else
        chk("bypass_same_cycle", rd_a, 64'h0);
`endif
        check_reads("bypass_pre");
        tick();
        idle(); #1;
        chk("bypass_next_cycle", rd_a, 64'hABCD);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            unit   = 2'($urandom_range(0, 3));
            en1    = 1'($urandom_range(0, 1));
            en2    = 1'($urandom_range(0, 1));
            a1     = 6'($urandom);
            a2     = 6'($urandom);
            v1     = {32'($urandom), 32'($urandom)};
            v2     = {32'($urandom), 32'($urandom)};
            resv   = ($urandom_range(0, 2) != 0);
            resv_a = 5'($urandom);
            ra_a   = ($urandom_range(0, 3) == 0) ? a1[4:0] : 5'($urandom);
            ra_b   = ($urandom_range(0, 3) == 0) ? a2[4:0] : 5'($urandom);
            ra_c   = 5'($urandom);
            #1;
            check_reads("rand_pre");
            tick();
            check_state("rand_post");
        end

        // Asynchronous reset between edges with busy bits outstanding.
        idle();
        resv = 1; resv_a = 5'd17;
        en1 = 1; a1 = 6'd17; v1 = 64'h77; unit = 2'd0;
        tick();
        idle();
        resv = 1; resv_a = 5'd17;
        tick();
        idle();
        ra_a = 17; ra_b = 7; ra_c = 12; #1;
        chk("pre_async_busy", 64'(bz_a), 64'd1);
        reset_n = 0;
        #1;
        model_reset();
        check_reads("async_rst");
        check_state("async_rst");
        chk("async_rst_data17", rd_a, 64'd0);
        tick();
        reset_n = 1;
        #1;
        check_reads("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_reg_file.md
# writeback_reg_file

Architected-state stage fed directly by the writeback mux. It takes the mux's registered reg1/reg2 writeback bundle and commits it into the 32 x 64-bit GPR file, the 32-bit condition register and the XER OV/CA bits. It serves three combinational GPR read ports to decode/dispatch, and keeps a per-GPR busy scoreboard so dispatch can stall on in-flight results.

## Interface
Parameters:
- regWidth, 5, GPR index width; numRegs = 2**regWidth
- dataWidth, 64, GPR width
- FXUnitCode, 0, fixed-point unit code on functionalUnitCode_i
- LdStUnitCode, 2, load/store unit code

Ports (clock and reset first):
- clock_i  in  1  single clock, all state updates on rising edge
- reset_i  in  1  asynchronous, active-low reset
- functionalUnitCode_i  in  2  unit that produced this writeback
- reg1WritebackEnable_i  in  1  port-1 GPR write request
- reg2WritebackEnable_i  in  1  FX: CR/XER update; LS: second GPR write (update-form base)
- reg1WritebackAddress_i  in  6  port-1 GPR index; only bits [1:5] used
- reg2WritebackAddress_i  in  6  FX: bits [3:5] = CR field 0-7; LS: bits [1:5] = GPR index
- reg1WritebackVal_i  in  64  port-1 data
- reg2WritebackVal_i  in  64  FX: bits [0:3] = LT,GT,EQ,SO, bit 4 = OV, bit 5 = CA; LS: GPR data
- readAddrA_i / readAddrB_i / readAddrC_i  in  5 each  read indices
- readDataA_o / readDataB_o / readDataC_o  out  64 each  read data
- readBusyA_o / readBusyB_o / readBusyC_o  out  1 each  scoreboard bit for the addressed GPR
- reserveEnable_i  in  1  dispatch marks a destination GPR in flight
- reserveAddr_i  in  5  GPR to mark busy
- cr_o  out  32  condition register
- xerOV_o, xerCA_o  out  1 each  XER overflow / carry

## Operation
- GPR write candidates: port1 = reg1WritebackEnable_i (either unit). port2 = reg2WritebackEnable_i when unit is LdStUnitCode.
- CR/XER update happens when unit is FXUnitCode and reg2WritebackEnable_i is set. The CR field (bits 4f..4f+3) is loaded from reg2WritebackVal_i[0:3]. xerOV/xerCA are loaded from bits 4 and 5. When SO=1, xerOV is also set.
- Unit codes other than FX/LS: reg2 is ignored; reg1 still writes.
- Port1 and port2 targeting the same GPR: port1 value wins.
- Scoreboard: every committed GPR write clears busy for that index. reserveEnable_i sets busy for reserveAddr_i.
- Set and clear of the same index on the same edge: set wins, because it represents a new producer.
- Reads are combinational from the array. GPR 0 is an ordinary register; there is no hardwired zero.

## Timing
- Write latency: data is presented in cycle N and is visible in the array after the rising edge ending N.
- Scoreboard: reserve at edge N, so readBusy is high from N+1. Clear at the writeback edge.
- Reset (asynchronous, low): all GPRs = 0, cr_o = 0, xerOV_o = xerCA_o = 0, all busy bits = 0.
  - Writes and reserves presented during reset are dropped.
  - Reset mid-operation discards in-flight busy state.
- When readAddr equals a same-cycle write address, see Configuration.

## Configuration
- WB_BYPASS_EN defined: readData returns the same-cycle writeback value (port1 has priority over port2). readBusy for that index reads 0, unless a same-cycle reserve hits that index.
- WB_BYPASS_EN undefined: reads return the array contents only. The new value and the busy clear become visible one cycle later.

## Structure
- Shared package holds:
  - unit codes (FXUnitCode, LdStUnitCode)
  - regWidth/dataWidth
  - CR field bit positions (LT/GT/EQ/SO)
  - XER OV/CA positions in reg2WritebackVal
- One sub-module: regfile_scoreboard, holding the 32 busy flops, the set/clear priority, and three busy read ports with optional bypass.

## Test plan
- Reset then read: deassert reset, read GPRs 0/5/31 -> all 0, busy 0, cr_o=0.
- FX write: unit=0, reg1En, addr 7, val 0xDEADBEEF00000001 -> next cycle GPR7 = that value. Same cycle with reg2En, CR field 2, val[0:5]=101101 -> cr_o bits 8-11 = 1011, xerOV=1, xerCA=1.
- LS dual write: unit=2, reg1 addr 3 = 0x11, reg2 addr 4 = 0x22 -> GPR3=0x11, GPR4=0x22. Then repeat both with addr 9 -> GPR9 = port1 value.
- Scoreboard: reserve 12 at edge N -> readBusy for 12 is 1 from N+1. Writeback 12 and reserve 12 on the same edge -> stays 1. Lone writeback -> 0.
- Bypass: write GPR 20 = 0xABCD while readAddrA=20 -> with WB_BYPASS_EN, readDataA=0xABCD in the same cycle. Without it, readDataA is the old value and becomes 0xABCD next cycle.
- Async reset mid-stream: assert reset between edges with busy bits set -> all outputs 0 immediately, without waiting for a clock edge.
